mod_shiftrows_stream: RTL
=========================

Name: mod_shiftrows_stream

Overview:
- Row-serial ShiftRows / InvShiftRows unit for the AES256 datapath. One state row is accepted per cycle over a valid/ready handshake.
- Each row is rotated by its Rijndael offset and passed downstream through a 2-entry output buffer, so the unit never drops data under backpressure.
- Generalises the fixed 4-column encrypt shifter:
  - parametrised column count and byte width;
  - encrypt/decrypt mode;
  - row-index tagging and a synchronous resync input.

Parameters:
- NB, 4, columns per state row (4..8); selects the Rijndael shift-offset table.
- W, 8, bits per state element.
- ROWS, 4, rows per state (fixed by AES; parameter exists for index width only).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- sync_clr  in  1  synchronous flush: row counter to 0, buffer emptied
- inv  in  1  0 = ShiftRows (left rotate), 1 = InvShiftRows (right rotate); sampled at row 0
- in_valid  in  1  input row valid
- in_ready  out  1  unit can accept a row
- in_row  in  [NB-1:0][W-1:0]  input row; index 0 = column 0
- out_valid  out  1  output row valid
- out_ready  in  1  downstream accepts the row
- out_row  out  [NB-1:0][W-1:0]  rotated row
- out_row_idx  out  [$clog2(ROWS)-1:0]  row number of out_row
- out_sof  out  1  high with row 0 of each state

Behaviour:
- Reset: clk domain with asynchronous active-low resetn.
  - While resetn=0: out_valid=0, out_row=0, out_row_idx=0, out_sof=0, in_ready=1.
  - Internally: row counter=0, buffer count=0, latched mode=0.
- Accept: occurs when in_valid & in_ready.
  - The row counter increments on each accept and wraps ROWS-1 -> 0.
- Mode latch: on an accept with counter==0, the latched mode takes inv.
  - Rows 1..ROWS-1 use the latched mode; inv changes mid-state are ignored.
- Shift offset s(r):
  - NB<=6: s = r (0,1,2,3).
  - NB=7: 0,1,2,4.
  - NB=8: 0,1,3,4.
- Rotation formulas:
  - Encrypt: out[c] = in[(c+s) mod NB].
  - Decrypt: out[c] = in[(c-s+NB) mod NB].
- Rotation is combinational on the input. The rotated row, its index and sof (= idx==0) are written into the buffer on accept.
- Buffer: 2-entry FIFO, head drives the out_* ports.
  - Latency: 1 cycle from accept to out_valid when the buffer is empty.
  - in_ready = (count<2), registered from the count. Throughput is 1 row/cycle while out_ready=1.
  - Pop occurs when out_valid & out_ready; the head advances.
  - Push and pop in the same cycle leave the count unchanged.
  - Full (count=2): in_ready=0, and in_valid is ignored.
  - Empty: out_valid=0; out_row holds its last value (no X).
  - out_* are stable while out_valid & !out_ready.
- sync_clr has priority over accept and pop in the same cycle.
  - The concurrent input is discarded.
  - Next cycle: count=0, counter=0, out_valid=0.
- resetn asserted mid-state: immediate return to the reset values. The partial state is lost and not resumed.
- No internal state-completion error flag. The row index makes misalignment visible downstream.

Decomposition:
- Package aes_shift_pkg holds:
  - typedef row_t (packed [NB-1:0][W-1:0]);
  - function shift_amt(nb, row) returning the offset table;
  - localparam ROWS = 4;
  - enum mode_e {SHIFT_ENC, SHIFT_DEC}.
- Sub-module mod_row_rotator: purely combinational NB x W rotator taking the row, s and mode.
  - Reused by the key-schedule RotWord path.
  - FIFO and counter stay in the top.

Test Plan:
1. Reset then release, with in_valid=0 -> out_valid=0, out_row=0, in_ready=1 on the first clock after release.
2. NB=4, inv=0, back-to-back rows 00010203, 10111213, 20212223, 30313233 (byte0 first), out_ready=1:
   - outputs 00010203, 11121310, 22232021, 33303132;
   - out_row_idx 0,1,2,3; out_sof only on the first row;
   - latency 1 cycle.
3. NB=4, inv=1, same input:
   - row1 -> 13101112, row2 -> 22232021, row3 -> 31323330;
   - toggling inv to 0 while row 2 is presented keeps the decrypt result; the next row 0 uses the new mode.
4. Streaming with out_ready=0 for 6 cycles:
   - in_ready drops after exactly 2 accepts;
   - out_row is held constant;
   - on release all rows exit in order, none lost or duplicated.
5. sync_clr asserted after 2 rows, with a simultaneous in_valid:
   - buffer empties, the row is discarded;
   - the next accepted row is tagged out_row_idx=0 / out_sof=1 and is not rotated.
6. NB=8, inv=0, row3 input 0..7 -> 04050607 00010203; row2 -> 03040506 07000102.
   - resetn pulse mid-state returns all outputs to the reset values asynchronously.

Source files
------------

// File: rtl/aes_shift_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aes_shift_pkg
// Description : Shared types and the Rijndael ShiftRows offset table used by
//               the row-serial ShiftRows unit and the key-schedule rotator.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_shift_pkg;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned DEF_NB = 4;
    localparam int unsigned DEF_W  = 8;

    // Row type for the default (AES, 4-column, byte) configuration.
    typedef logic [DEF_NB-1:0][DEF_W-1:0] row_t;

    typedef enum logic {
        SHIFT_ENC = 1'b0,
        SHIFT_DEC = 1'b1
    } mode_e;

    // Rijndael shift offsets: C1 is always 1; C2/C3 grow for wide blocks.
    function automatic int unsigned shift_amt(input int unsigned nb,
                                              input int unsigned row);
        int unsigned s;
        case (row)
            0:       s = 0;
            1:       s = 1;
            2:       s = (nb == 8) ? 3 : 2;
            3:       s = (nb >= 7) ? 4 : 3;
            default: s = 0;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_row_rotator.sv
`default_nettype none
// ============================================================================
// Module      : mod_row_rotator
// Description : Purely combinational NB x W element rotator.
//               Encrypt: o_row[c] = i_row[(c+s) mod NB]
//               Decrypt: o_row[c] = i_row[(c-s+NB) mod NB]
// Ports       : i_row   - input row, element 0 in the least significant slot
//               i_shift - rotation amount s (0..NB)
//               i_dec   - 0 = left rotate, 1 = right rotate
//               o_row   - rotated row
// Revision    : 1.0 - initial release
// ============================================================================
module mod_row_rotator #(
    parameter int NB = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(NB + 1)
) (
    input  logic [NB-1:0][W-1:0] i_row,
    input  logic [SW-1:0]        i_shift,
    input  logic                 i_dec,
    output logic [NB-1:0][W-1:0] o_row
);

    localparam int BW = $clog2(2 * NB * W);

    logic [2*NB*W-1:0] w_dbl;
    logic [SW-1:0]     w_off;
    logic [BW-1:0]     w_base;

    // A window of NB elements slid over two copies of the row is a rotation;
    // a right rotate by s is the same window at offset NB-s.
    assign w_dbl  = {i_row, i_row};
    assign w_off  = i_dec ? (SW'(NB) - i_shift) : i_shift;
    assign w_base = BW'(w_off) * BW'(W);
    assign o_row  = w_dbl[w_base +: NB*W];

endmodule
`default_nettype wire

// File: rtl/mod_shiftrows_stream.sv
`default_nettype none
// ============================================================================
// Module      : mod_shiftrows_stream
// Description : Row-serial ShiftRows / InvShiftRows unit. Accepts one state
//               row per cycle over valid/ready, rotates it by its Rijndael
//               offset and presents it through a 2-entry output buffer.
// Ports       : clk, resetn   - clock, asynchronous active-low reset
//               sync_clr      - synchronous flush of row counter and buffer
//               inv           - 0 ShiftRows, 1 InvShiftRows (taken at row 0)
//               in_valid/in_ready/in_row        - input row handshake
//               out_valid/out_ready/out_row     - output row handshake
//               out_row_idx   - row number of out_row
//               out_sof       - high with row 0 of each state
// Revision    : 1.0 - initial release
// ============================================================================
module mod_shiftrows_stream #(
    parameter int NB   = 4,
    parameter int W    = 8,
    parameter int ROWS = aes_shift_pkg::ROWS
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 sync_clr,
    input  logic                 inv,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NB-1:0][W-1:0] in_row,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NB-1:0][W-1:0] out_row,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row_idx,
    output logic                 out_sof
);

    import aes_shift_pkg::*;

    localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW = $clog2(NB + 1);

    // Row counter and latched mode
    logic [IW-1:0]        r_cnt;
    mode_e                r_mode;

    // Output buffer: head register drives the ports, skid holds the second row
    logic [1:0]           r_count;
    logic                 r_in_ready;
    logic [NB-1:0][W-1:0] r_head_row;
    logic [IW-1:0]        r_head_idx;
    logic                 r_head_sof;
    logic [NB-1:0][W-1:0] r_skid_row;
    logic [IW-1:0]        r_skid_idx;
    logic                 r_skid_sof;

    logic                 w_accept;
    logic                 w_pop;
    logic                 w_first;
    logic                 w_dec;
    logic [SW-1:0]        w_shift;
    logic [NB-1:0][W-1:0] w_rot;
    logic [IW-1:0]        w_cnt_nxt;
    logic [1:0]           w_count_nxt;

    assign w_accept = in_valid & r_in_ready;
    assign w_pop    = (r_count != 2'd0) & out_ready;
    assign w_first  = (r_cnt == '0);

    // Row 0 takes the live mode; later rows use the value latched at row 0.
    assign w_dec    = w_first ? inv : (r_mode == SHIFT_DEC);
    assign w_shift  = SW'(shift_amt(NB, 32'(r_cnt)));

    assign w_cnt_nxt = (r_cnt == IW'(ROWS - 1)) ? '0 : (r_cnt + 1'b1);

    mod_row_rotator #(
        .NB (NB),
        .W  (W),
        .SW (SW)
    ) u_rot (
        .i_row   (in_row),
        .i_shift (w_shift),
        .i_dec   (w_dec),
        .o_row   (w_rot)
    );

    always_comb begin
        w_count_nxt = r_count;
        case ({w_accept, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt      <= '0;
            r_mode     <= SHIFT_ENC;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
            r_head_row <= '0;
            r_head_idx <= '0;
            r_head_sof <= 1'b0;
            r_skid_row <= '0;
            r_skid_idx <= '0;
            r_skid_sof <= 1'b0;
        end else if (sync_clr) begin
            // Flush wins over any concurrent accept or pop; the head data
            // registers keep their value so out_row never goes undefined.
            r_cnt      <= '0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt < 2'd2);

            if (w_accept) begin
                r_cnt <= w_cnt_nxt;
                if (w_first) begin
                    r_mode <= inv ? SHIFT_DEC : SHIFT_ENC;
                end
            end

            // A full buffer never accepts, so accept with count==2 cannot occur.
            if (w_accept && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop))) begin
                r_head_row <= w_rot;
                r_head_idx <= r_cnt;
                r_head_sof <= w_first;
            end else if (w_accept) begin
                r_skid_row <= w_rot;
                r_skid_idx <= r_cnt;
                r_skid_sof <= w_first;
            end else if (w_pop && (r_count == 2'd2)) begin
                r_head_row <= r_skid_row;
                r_head_idx <= r_skid_idx;
                r_head_sof <= r_skid_sof;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_count != 2'd0);
    assign out_row     = r_head_row;
    assign out_row_idx = r_head_idx;
    assign out_sof     = r_head_sof;

endmodule
`default_nettype wire
